// File: rtl/axi_rom_pkg.sv
// Shared constants and types for the AXI read-only ROM slave.
package axi_rom_pkg;

  // AXI channel widths used on the slave ports
  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  // Only full 32-bit word transfers are served
  localparam logic [AXI_SIZE_W-1:0] SIZE_WORD = 3'b010;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

  localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
    logic [AXI_RESP_W-1:0] resp;
  } rbeat_t;

  // WRAP bursts must be 2, 4, 8 or 16 beats long
  function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/rom_rdata_fifo.sv
// Return buffer for R beats; head is readable combinationally so RVALID
// and the beat fields come straight from storage.
module rom_rdata_fifo
  import axi_rom_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  rbeat_t           push_beat,
  input  logic             pop,
  output rbeat_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  rbeat_t           mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  // A push into a full buffer is accepted only when a pop frees a slot
  assign do_push = push && (!full || do_pop);

  // Beat storage, written at the tail
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_beat;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/axi_rom_burst_slave.sv
// AXI4 read-only slave in front of a synchronous ROM macro. One burst at a
// time; ROM reads are issued against a credit count so every DO sample has
// a reserved return-buffer slot.
module axi_rom_burst_slave
  import axi_rom_pkg::*;
#(
  parameter int          ROM_ADDR_W = 12,
  parameter int          ROM_LAT    = 1,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [AXI_ID_W-1:0]    ARID,
  input  logic [AXI_ADDR_W-1:0]  ARADDR,
  input  logic [AXI_LEN_W-1:0]   ARLEN,
  input  logic [AXI_SIZE_W-1:0]  ARSIZE,
  input  logic [AXI_BURST_W-1:0] ARBURST,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [AXI_ID_W-1:0]    RID,
  output logic [AXI_DATA_W-1:0]  RDATA,
  output logic [AXI_RESP_W-1:0]  RRESP,
  output logic                   RLAST,
  output logic                   RVALID,
  input  logic                   RREADY,
  input  logic [AXI_DATA_W-1:0]  DO,
  output logic                   CS,
  output logic                   OE,
  output logic [ROM_ADDR_W-1:0]  A
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e                  state_reg;
  logic [AXI_ID_W-1:0]     id_reg;
  logic [ROM_ADDR_W-1:0]   addr_reg;
  logic [ROM_ADDR_W-1:0]   addr_next;
  logic [AXI_LEN_W-1:0]    len_reg;
  logic [AXI_BURST_W-1:0]  burst_reg;
  logic [AXI_RESP_W-1:0]   cap_resp_reg;
  logic [AXI_LEN_W:0]      issue_cnt_reg;

  logic                    ar_decerr;
  logic                    ar_slverr;
  logic [AXI_RESP_W-1:0]   ar_resp;
  logic                    issue;
  logic                    issue_ok;
  logic                    issue_last;
  logic [31:0]             in_flight;
  logic [31:0]             credit_used;

  logic [ROM_LAT-1:0]      pipe_valid;
  logic [ROM_LAT-1:0]      pipe_last;
  logic [AXI_RESP_W-1:0]   pipe_resp [ROM_LAT];

  rbeat_t                  push_beat;
  rbeat_t                  head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic                    rvalid_int;
  logic                    r_pop;
  logic                    unused_addr_bits;

  // Byte-lane bits are irrelevant for word-only access
  assign unused_addr_bits = ^ARADDR[1:0];

  // Response class of an incoming request, frozen at capture
  assign ar_decerr = (ARADDR[31:ROM_ADDR_W+2] != BASE_ADDR[31:ROM_ADDR_W+2]);
  assign ar_slverr = (ARSIZE != SIZE_WORD) || (ARBURST == 2'b11) ||
                     ((ARBURST == BURST_WRAP) && !wrap_len_ok(ARLEN));
  assign ar_resp   = ar_decerr ? RESP_DECERR : (ar_slverr ? RESP_SLVERR : RESP_OKAY);

  // Count reads already issued but not yet landed in the buffer
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      in_flight = in_flight + 32'(pipe_valid[i]);
    end
  end

  assign credit_used = in_flight + 32'(fifo_count);
  assign issue       = !reset && (state_reg == RUN) &&
                       (issue_cnt_reg <= {1'b0, len_reg}) &&
                       (credit_used < 32'(FIFO_DEPTH)) && !fifo_full;
  assign issue_ok    = issue && (cap_resp_reg == RESP_OKAY);
  assign issue_last  = (issue_cnt_reg == {1'b0, len_reg});

  assign CS = issue_ok;
  assign OE = issue_ok;
  assign A  = issue_ok ? addr_reg : '0;

  // Next beat address; WRAP relies on len being 2^k-1 so len doubles as the mask
  always_comb begin
    addr_next = addr_reg;
    case (burst_reg)
      BURST_INCR: addr_next = addr_reg + ROM_ADDR_W'(1);
      BURST_WRAP: addr_next = (addr_reg & ~ROM_ADDR_W'(len_reg)) |
                              ((addr_reg + ROM_ADDR_W'(1)) & ROM_ADDR_W'(len_reg));
      default:    addr_next = addr_reg;
    endcase
  end

  // Burst control: capture in IDLE, issue and retire in RUN
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      id_reg        <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      burst_reg     <= '0;
      cap_resp_reg  <= RESP_OKAY;
      issue_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ARVALID) begin
            id_reg        <= ARID;
            addr_reg      <= ARADDR[ROM_ADDR_W+1:2];
            len_reg       <= ARLEN;
            burst_reg     <= ARBURST;
            cap_resp_reg  <= ar_resp;
            issue_cnt_reg <= '0;
            state_reg     <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            issue_cnt_reg <= issue_cnt_reg + 1'b1;
            addr_reg      <= addr_next;
          end
          if (r_pop && head.last) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Latency pipe tracking each issued read until DO is valid
  for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_pipe
    logic                  valid_reg;
    logic                  last_reg;
    logic [AXI_RESP_W-1:0] resp_reg;
    logic                  valid_in;
    logic                  last_in;
    logic [AXI_RESP_W-1:0] resp_in;

    if (gi == 0) begin : g_first
      assign valid_in = issue;
      assign last_in  = issue_last;
      assign resp_in  = cap_resp_reg;
    end else begin : g_next
      assign valid_in = pipe_valid[gi-1];
      assign last_in  = pipe_last[gi-1];
      assign resp_in  = pipe_resp[gi-1];
    end

    // Advance one stage per cycle
    always_ff @(posedge clock) begin
      if (reset) begin
        valid_reg <= 1'b0;
        last_reg  <= 1'b0;
        resp_reg  <= RESP_OKAY;
      end else begin
        valid_reg <= valid_in;
        last_reg  <= valid_in && last_in;
        resp_reg  <= resp_in;
      end
    end

    assign pipe_valid[gi] = valid_reg;
    assign pipe_last[gi]  = last_reg;
    assign pipe_resp[gi]  = resp_reg;
  end

  // Error beats carry zero data regardless of what the ROM drives
  always_comb begin
    push_beat.data = (pipe_resp[ROM_LAT-1] == RESP_OKAY) ? DO : '0;
    push_beat.last = pipe_last[ROM_LAT-1];
    push_beat.resp = pipe_resp[ROM_LAT-1];
  end

  rom_rdata_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (pipe_valid[ROM_LAT-1]),
    .push_beat(push_beat),
    .pop      (r_pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign rvalid_int = !fifo_empty && !reset;
  assign r_pop      = rvalid_int && RREADY;

  assign ARREADY = (state_reg == IDLE) && !reset;
  assign RVALID  = rvalid_int;
  assign RDATA   = rvalid_int ? head.data : '0;
  assign RRESP   = rvalid_int ? head.resp : RESP_OKAY;
  assign RLAST   = rvalid_int && head.last;
  assign RID     = reset ? '0 : id_reg;

endmodule

// File: tb/tb_axi_rom_burst_slave.sv
// Directed bench for axi_rom_burst_slave with a behavioural ROM on each instance.
module tb_axi_rom_burst_slave;

  localparam int MAXC = 64;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic [3:0]  ARID    = '0;
  logic [31:0] ARADDR  = '0;
  logic [3:0]  ARLEN   = '0;
  logic [2:0]  ARSIZE  = 3'b010;
  logic [1:0]  ARBURST = 2'b01;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY  = 1'b0;
  logic [31:0] DO;
  logic        CS;
  logic        OE;
  logic [11:0] A;

  logic        arvalid3 = 1'b0;
  logic        arready3;
  logic [3:0]  rid3;
  logic [31:0] rdata3;
  logic [1:0]  rresp3;
  logic        rlast3;
  logic        rvalid3;
  logic        rready3 = 1'b0;
  logic [31:0] do3;
  logic        cs3;
  logic        oe3;
  logic [11:0] a3;
  logic [31:0] rom3_s0;
  logic [31:0] rom3_s1;

  int checks = 0;
  int errors = 0;

  // per-cycle record of the last burst
  logic        rec_cs [MAXC];
  logic        rec_oe [MAXC];
  logic        rec_rvalid [MAXC];
  logic        rec_rready [MAXC];
  logic        rec_rlast [MAXC];
  logic        rec_arready [MAXC];
  logic [31:0] rec_rdata [MAXC];
  int          ncyc, last_cyc, n_addr, n_beats;
  logic [11:0] a_log [16];
  int          a_cyc [16];
  logic [31:0] beat_data [16];
  logic [1:0]  beat_resp [16];
  logic        beat_last [16];
  logic [3:0]  beat_id [16];
  int          beat_cyc [16];

  axi_rom_burst_slave #(
    .ROM_ADDR_W(12), .ROM_LAT(1), .FIFO_DEPTH(4), .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clock(clock), .reset(reset), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .DO(DO), .CS(CS), .OE(OE), .A(A)
  );

  axi_rom_burst_slave #(
    .ROM_ADDR_W(12), .ROM_LAT(3), .FIFO_DEPTH(5), .BASE_ADDR(32'h0000_0000)
  ) dut3 (
    .clock(clock), .reset(reset), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(arvalid3), .ARREADY(arready3),
    .RID(rid3), .RDATA(rdata3), .RRESP(rresp3), .RLAST(rlast3), .RVALID(rvalid3),
    .RREADY(rready3), .DO(do3), .CS(cs3), .OE(oe3), .A(a3)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return {20'hC0DE0, a};
  endfunction

  // ROM models: one-cycle and three-cycle read latency
  always @(posedge clock) DO <= (CS && OE) ? rom_word(A) : 32'hBAD0_BAD0;
  always @(posedge clock) begin
    rom3_s0 <= (cs3 && oe3) ? rom_word(a3) : 32'hBAD0_BAD0;
    rom3_s1 <= rom3_s0;
    do3     <= rom3_s1;
  end

  function automatic logic rr(input int mode, input int c);
    return (mode == 0) ? 1'b1 : ((c % 3) == 0);
  endfunction

  // Issue one burst on the main instance and record every cycle until the
  // cycle after the last beat (or MAXC cycles).
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
    n_addr = 0; n_beats = 0; last_cyc = -1; ncyc = 0;
    @(posedge clock); #1;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1; RREADY = rr(mode, 0);
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clock);
      rec_cs[c] = CS; rec_oe[c] = OE; rec_rvalid[c] = RVALID; rec_rready[c] = RREADY;
      rec_rlast[c] = RLAST; rec_arready[c] = ARREADY; rec_rdata[c] = RDATA;
      if (CS && n_addr < 16) begin
        a_log[n_addr] = A; a_cyc[n_addr] = c; n_addr++;
      end
      if (RVALID && RREADY && n_beats < 16) begin
        beat_data[n_beats] = RDATA; beat_resp[n_beats] = RRESP; beat_last[n_beats] = RLAST;
        beat_id[n_beats] = RID; beat_cyc[n_beats] = c; n_beats++;
        if (RLAST) last_cyc = c;
      end
      ncyc = c + 1;
      if (last_cyc >= 0 && c == last_cyc + 1) break;
      @(posedge clock); #1;
      ARVALID = 1'b0; RREADY = rr(mode, c + 1);
    end
    RREADY = 1'b1;
    $display("burst id=%0h addr=%08h len=%0d burst=%0d size=%0d reads=%0d beats=%0d last_cycle=%0d",
             id, addr, len, burst, size, n_addr, n_beats, last_cyc);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (ARREADY !== 1'b0) begin errors++; $display("FAIL reset_arready got %b want 0", ARREADY); end
    checks++; if (RVALID !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", RVALID); end
    checks++; if (CS !== 1'b0 || OE !== 1'b0) begin errors++; $display("FAIL reset_cs_oe got %b%b want 00", CS, OE); end
    checks++; if (RDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata got %08h want 0", RDATA); end
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    checks++; if (ARREADY !== 1'b1) begin errors++; $display("FAIL post_reset_arready got %b want 1", ARREADY); end
    checks++; if (RVALID !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid got %b want 0", RVALID); end
  endtask

  task automatic test_incr;
    run_burst(4'h5, 32'h10, 4'd3, 3'b010, 2'b01, 0);
    checks++; if (last_cyc < 0) begin errors++; $display("FAIL incr_timeout got none want RLAST"); end
    checks++; if (n_addr != 4) begin errors++; $display("FAIL incr_reads got %0d want 4", n_addr); end
    for (int i = 0; i < 4 && i < n_addr; i++) begin
      checks++; if (a_log[i] !== 12'(4 + i) || a_cyc[i] != 1 + i) begin errors++;
        $display("FAIL incr_addr[%0d] got A=%0h cyc=%0d want A=%0h cyc=%0d", i, a_log[i], a_cyc[i], 4 + i, 1 + i); end
    end
    checks++; if (rec_oe[1] !== 1'b1) begin errors++; $display("FAIL incr_oe got %b want 1", rec_oe[1]); end
    checks++; if (n_beats != 4) begin errors++; $display("FAIL incr_beats got %0d want 4", n_beats); end
    for (int i = 0; i < 4 && i < n_beats; i++) begin
      checks++; if (beat_data[i] !== 32'hC0DE_0004 + 32'(i) || beat_resp[i] !== 2'b00 ||
                    beat_last[i] !== (i == 3) || beat_cyc[i] != 3 + i || beat_id[i] !== 4'h5) begin errors++;
        $display("FAIL incr_beat[%0d] got d=%08h r=%0b l=%b cyc=%0d id=%0h want d=%08h r=00 l=%b cyc=%0d id=5",
                 i, beat_data[i], beat_resp[i], beat_last[i], beat_cyc[i], beat_id[i],
                 32'hC0DE_0004 + 32'(i), (i == 3), 3 + i); end
    end
    checks++; if (rec_arready[1] !== 1'b0) begin errors++; $display("FAIL incr_arready_busy got %b want 0", rec_arready[1]); end
    checks++; if (last_cyc >= 0 && rec_arready[last_cyc + 1] !== 1'b1) begin errors++;
      $display("FAIL incr_arready_after got %b want 1", rec_arready[last_cyc + 1]); end
  endtask

  task automatic test_wrap;
    int exp_a [4] = '{7, 4, 5, 6};
    run_burst(4'h1, 32'h1C, 4'd3, 3'b010, 2'b10, 0);
    checks++; if (n_addr != 4 || n_beats != 4) begin errors++;
      $display("FAIL wrap_count got reads=%0d beats=%0d want 4/4", n_addr, n_beats); end
    for (int i = 0; i < 4 && i < n_addr && i < n_beats; i++) begin
      checks++; if (a_log[i] !== 12'(exp_a[i]) || beat_data[i] !== 32'hC0DE_0000 + 32'(exp_a[i])) begin errors++;
        $display("FAIL wrap_beat[%0d] got A=%0h d=%08h want A=%0h d=%08h", i, a_log[i], beat_data[i],
                 exp_a[i], 32'hC0DE_0000 + 32'(exp_a[i])); end
    end
  endtask

  task automatic test_fixed;
    run_burst(4'h2, 32'h8, 4'd2, 3'b010, 2'b00, 0);
    checks++; if (n_addr != 3 || n_beats != 3) begin errors++;
      $display("FAIL fixed_count got reads=%0d beats=%0d want 3/3", n_addr, n_beats); end
    for (int i = 0; i < 3 && i < n_addr && i < n_beats; i++) begin
      checks++; if (a_log[i] !== 12'h2 || beat_data[i] !== 32'hC0DE_0002 || beat_last[i] !== (i == 2)) begin errors++;
        $display("FAIL fixed_beat[%0d] got A=%0h d=%08h l=%b want A=2 d=c0de0002 l=%b", i, a_log[i],
                 beat_data[i], beat_last[i], (i == 2)); end
    end
  endtask

  task automatic test_backpressure;
    int stalls = 0;
    run_burst(4'h7, 32'h40, 4'd7, 3'b010, 2'b01, 1);
    checks++; if (n_beats != 8 || n_addr != 8) begin errors++;
      $display("FAIL bp_count got reads=%0d beats=%0d want 8/8", n_addr, n_beats); end
    for (int i = 0; i < 8 && i < n_beats; i++) begin
      checks++; if (beat_data[i] !== 32'hC0DE_0010 + 32'(i) || beat_last[i] !== (i == 7)) begin errors++;
        $display("FAIL bp_beat[%0d] got d=%08h l=%b want d=%08h l=%b", i, beat_data[i], beat_last[i],
                 32'hC0DE_0010 + 32'(i), (i == 7)); end
    end
    for (int c = 0; c + 1 < ncyc; c++) begin
      if (rec_rvalid[c] && !rec_rready[c]) begin
        stalls++;
        checks++; if (rec_rvalid[c+1] !== 1'b1 || rec_rdata[c+1] !== rec_rdata[c] || rec_rlast[c+1] !== rec_rlast[c]) begin
          errors++; $display("FAIL bp_hold cyc %0d got v=%b d=%08h want v=1 d=%08h", c + 1, rec_rvalid[c+1],
                             rec_rdata[c+1], rec_rdata[c]); end
      end
    end
    checks++; if (stalls < 1) begin errors++; $display("FAIL bp_stalls got %0d want >=1", stalls); end
  endtask

  task automatic test_errors;
    logic any_oe;
    run_burst(4'h3, 32'h0001_0040, 4'd1, 3'b010, 2'b01, 0);
    any_oe = 1'b0;
    for (int c = 0; c < ncyc; c++) any_oe = any_oe | rec_oe[c];
    checks++; if (n_addr != 0 || any_oe !== 1'b0) begin errors++;
      $display("FAIL decerr_cs got reads=%0d oe=%b want 0/0", n_addr, any_oe); end
    checks++; if (n_beats != 2) begin errors++; $display("FAIL decerr_beats got %0d want 2", n_beats); end
    for (int i = 0; i < 2 && i < n_beats; i++) begin
      checks++; if (beat_resp[i] !== 2'b11 || beat_data[i] !== 32'h0 || beat_last[i] !== (i == 1)) begin errors++;
        $display("FAIL decerr_beat[%0d] got r=%0b d=%08h l=%b want r=11 d=0 l=%b", i, beat_resp[i],
                 beat_data[i], beat_last[i], (i == 1)); end
    end
    run_burst(4'h4, 32'h20, 4'd2, 3'b001, 2'b01, 0);
    checks++; if (n_beats != 3 || n_addr != 0) begin errors++;
      $display("FAIL slverr_size_count got reads=%0d beats=%0d want 0/3", n_addr, n_beats); end
    for (int i = 0; i < 3 && i < n_beats; i++) begin
      checks++; if (beat_resp[i] !== 2'b10 || beat_data[i] !== 32'h0) begin errors++;
        $display("FAIL slverr_size_beat[%0d] got r=%0b d=%08h want r=10 d=0", i, beat_resp[i], beat_data[i]); end
    end
    run_burst(4'h6, 32'h20, 4'd2, 3'b010, 2'b10, 0);
    checks++; if (n_beats != 3 || beat_resp[0] !== 2'b10 || beat_resp[2] !== 2'b10) begin errors++;
      $display("FAIL slverr_wrap got beats=%0d r0=%0b r2=%0b want 3/10/10", n_beats, beat_resp[0], beat_resp[2]); end
  endtask

  task automatic test_reset_mid;
    int pops = 0;
    @(posedge clock); #1;
    ARID = 4'h3; ARADDR = 32'h100; ARLEN = 4'd7; ARSIZE = 3'b010; ARBURST = 2'b01;
    ARVALID = 1'b1; RREADY = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (RVALID && RREADY) pops++;
      if (pops == 2) break;
      @(posedge clock); #1; ARVALID = 1'b0;
    end
    ARVALID = 1'b0;
    checks++; if (pops != 2) begin errors++; $display("FAIL mid_two_beats got %0d want 2", pops); end
    @(posedge clock); #1; reset = 1'b1;
    @(negedge clock);
    checks++; if (RVALID !== 1'b0 || CS !== 1'b0) begin errors++;
      $display("FAIL mid_reset_outputs got v=%b cs=%b want 0/0", RVALID, CS); end
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (RVALID !== 1'b0 || CS !== 1'b0 || ARREADY !== 1'b0) begin errors++;
      $display("FAIL mid_reset_hold got v=%b cs=%b ar=%b want 0/0/0", RVALID, CS, ARREADY); end
    @(posedge clock); #1; reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin errors++;
        $display("FAIL mid_after_release cyc %0d got v=%b ar=%b want 0/1", c, RVALID, ARREADY); end
      @(posedge clock); #1;
    end
    run_burst(4'h2, 32'h30, 4'd1, 3'b010, 2'b01, 0);
    checks++; if (n_beats != 2 || beat_data[0] !== 32'hC0DE_000C || beat_data[1] !== 32'hC0DE_000D ||
                  beat_last[1] !== 1'b1 || beat_resp[1] !== 2'b00) begin errors++;
      $display("FAIL mid_new_burst got n=%0d d0=%08h d1=%08h l1=%b want 2/c0de000c/c0de000d/1",
               n_beats, beat_data[0], beat_data[1], beat_last[1]); end
  endtask

  task automatic test_lat3;
    int first_a = -1;
    int first_rv = -1;
    int nb = 0;
    int lastc = -1;
    @(posedge clock); #1;
    ARID = 4'h9; ARADDR = 32'h10; ARLEN = 4'd3; ARSIZE = 3'b010; ARBURST = 2'b01;
    arvalid3 = 1'b1; rready3 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (cs3 && first_a < 0) first_a = c;
      if (rvalid3 && first_rv < 0) first_rv = c;
      if (rvalid3 && rready3) begin
        checks++; if (rdata3 !== 32'hC0DE_0004 + 32'(nb)) begin errors++;
          $display("FAIL lat3_beat[%0d] got %08h want %08h", nb, rdata3, 32'hC0DE_0004 + 32'(nb)); end
        nb++;
        if (rlast3) begin lastc = c; break; end
      end
      @(posedge clock); #1; arvalid3 = 1'b0;
    end
    arvalid3 = 1'b0;
    $display("burst lat3 id=9 addr=00000010 len=3 first_a=%0d first_rvalid=%0d beats=%0d last_cycle=%0d",
             first_a, first_rv, nb, lastc);
    checks++; if (first_a != 1) begin errors++; $display("FAIL lat3_first_a got %0d want 1", first_a); end
    checks++; if (first_rv != 5) begin errors++; $display("FAIL lat3_first_rvalid got %0d want 5", first_rv); end
    checks++; if (nb != 4 || lastc != 8) begin errors++;
      $display("FAIL lat3_throughput got beats=%0d last=%0d want 4/8", nb, lastc); end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_lat3();
    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
